// File: rtl/mul_hilo_pkg.sv
// Shared types for the HI/LO multiply unit: FSM states, settle-counter width and product word.
package mul_hilo_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  typedef logic [63:0] prod_t;
endpackage

// File: rtl/mul_hilo_unit_mul32.sv
// Combinational 32x32 -> 64 two's-complement multiplier; zero latency, no flow control.
module MUL32
  import mul_hilo_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output prod_t       p
);
  logic signed [63:0] w_a_ext;
  logic signed [63:0] w_b_ext;

  // Sign-extend to 64 bits so the truncated product is exact, including -2^31 * -2^31.
  assign w_a_ext = {{32{a[31]}}, a};
  assign w_b_ext = {{32{b[31]}}, b};
  assign p       = w_a_ext * w_b_ext;
endmodule

// File: rtl/mul_hilo_unit.sv
// HI/LO multiply unit: product lands in hi/lo LATENCY cycles after start; start and MTHI/MTLO ignored while busy.
// Optional per-operation unsigned multiply under `MUL_HILO_UNSIGNED_EN.
module mul_hilo_unit
  import mul_hilo_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        start,
`ifdef MUL_HILO_UNSIGNED_EN
  input  logic        is_unsigned,
`endif
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             w_accept;
  logic             w_capture;
  logic             w_wr_ok;
  prod_t            w_prod;
  prod_t            w_result;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = MUL;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = MUL;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_wr_ok = (r_state != MUL);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  MUL32 u_mul32 (
    .a (r_a),
    .b (r_b),
    .p (w_prod)
  );

`ifdef MUL_HILO_UNSIGNED_EN
  logic  r_uns;
  prod_t w_corr;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_uns <= 1'b0;
    end else if (w_accept) begin
      r_uns <= is_unsigned;
    end
  end

  // A set MSB was weighted -2^31 by the signed multiplier; adding other<<32 restores +2^31.
  assign w_corr   = (r_a[31] ? {r_b, 32'h0} : 64'h0) + (r_b[31] ? {r_a, 32'h0} : 64'h0);
  assign w_result = r_uns ? (w_prod + w_corr) : w_prod;
`else
  assign w_result = w_prod;
`endif

  // Capture only happens in MUL and writes only outside it, so the two never collide.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hi <= '0;
      lo <= '0;
    end else if (w_capture) begin
      {hi, lo} <= w_result;
    end else begin
      if (wr_hi && w_wr_ok) hi <= wr_data;
      if (wr_lo && w_wr_ok) lo <= wr_data;
    end
  end
endmodule

// File: doc/mul_hilo_unit.md
MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles the MUL32 product is allowed to settle (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port nRst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request for a new multiply; sampled on clk.
REQ-005 The block SHALL have ports a and b, input, 32 each, multiplicand and multiplier, sampled with start.
REQ-006 The block SHALL have port is_unsigned, input, 1, per-operation unsigned select (present only under REQ-020).
REQ-007 The block SHALL have ports wr_hi and wr_lo, input, 1 each, direct HI/LO load strobes (MTHI/MTLO).
REQ-008 The block SHALL have port wr_data, input, 32, data for wr_hi and wr_lo.
REQ-009 The block SHALL have ports busy and done, output, 1 each, operation in flight and one-cycle completion pulse.
REQ-010 The block SHALL have ports hi and lo, output, 32 each, registered upper and lower product words.

Function
REQ-011 FSM states SHALL be IDLE, MUL and DONE; start is accepted only in IDLE or DONE, which gives back-to-back issue.
REQ-012 Accepted start SHALL latch a, b (and is_unsigned) into operand registers, enter MUL and load the settle counter with LATENCY-1.
REQ-013 In MUL, busy SHALL be 1, the counter decrements each cycle, and start, wr_hi and wr_lo are ignored.
REQ-014 When the counter is 0 in MUL, the next edge SHALL load {hi,lo} with the 64-bit product of the latched operands and enter DONE.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle and busy 0; the next state is MUL if start=1, else IDLE.
REQ-016 Latency SHALL be fixed: with start sampled at edge E0, hi/lo update and done rises at edge E(LATENCY); operands changing after E0 have no effect.
REQ-017 The signed product SHALL be the exact two's-complement result for all operands, including 0x80000000 x 0x80000000 = 0x40000000_00000000.
REQ-018 wr_hi and wr_lo outside MUL SHALL load wr_data into hi or lo respectively on the next edge; both may assert together.
REQ-019 If start and wr_hi/wr_lo arrive in the same cycle, the write SHALL take effect and the later product capture SHALL overwrite it.

Configuration
REQ-020 With macro MUL_HILO_UNSIGNED_EN defined, is_unsigned SHALL exist and, when 1, {hi,lo} = signed product + (a[31] ? b<<32 : 0) + (b[31] ? a<<32 : 0) mod 2^64; without the macro, the port is absent and every operation is signed.

Reset
REQ-021 When nRst=0 (asynchronously, including mid-MUL), the block SHALL enter IDLE with hi=0, lo=0, busy=0, done=0, counter=0, operands=0.
REQ-022 After nRst deasserts, the first edge SHALL accept start normally; an aborted operation never writes hi/lo.

Structure
REQ-023 Package mul_hilo_pkg SHALL hold the state enum (IDLE, MUL, DONE), the counter width constant (4) and the 64-bit product type.
REQ-024 The combinational multiplier SHALL be a single instantiated sub-module, MUL32 (a, b -> 64-bit signed p), fed only from the operand registers.

Verification
REQ-025 Reset, then start with a=0x80000000, b=0x80000000 and LATENCY=2 -> busy for 2 cycles, then done=1 for 1 cycle, hi=0x40000000, lo=0x00000000.
REQ-026 a=0x80000000, b=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000; a=0x80000000, b=0x00000002 -> hi=0xFFFFFFFF, lo=0x00000000.
REQ-027 Back-to-back: start held high over 3 operations of (0xFFFFFFFF, 0xFFFFFFFF) -> three done pulses spaced LATENCY+1 cycles apart, each giving hi=0, lo=1; start during MUL is ignored.
REQ-028 wr_hi=1 with wr_data=0x12345678 in IDLE -> hi=0x12345678; wr_lo during MUL is ignored; wr_hi together with start -> hi=0x12345678 first, then overwritten by the product.
REQ-029 nRst pulsed low during MUL -> immediate hi=lo=0, busy=0, and no done pulse afterwards.
REQ-030 With MUL_HILO_UNSIGNED_EN, is_unsigned=1 and a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then 10^5 random operand pairs checked against a 64-bit reference model.
